err_recovery_ctrl: RTL and testbench

Clocked sequencer for one error-resilient pipeline stage. It accepts a token from the upstream stage and fires the sampling strobe. It then watches the two error detectors (`err0`, `err1`) during a check window and, on error, holds `goml` for a fixed recovery period. Finally it hands the token downstream over a four-phase `rreq`/`rack` handshake. It generates the `sample`/`goml` controls that the stage's `goML` gate logic consumes, and it keeps a saturating error count for monitoring.

---
 rtl/usc_ctrl_pkg.sv | 17 +
 rtl/sat_counter.sv | 21 ++
 rtl/err_recovery_ctrl.sv | 85 ++++++++
 tb/tb_err_recovery_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/usc_ctrl_pkg.sv
// usc_ctrl_pkg: shared state encoding and default timing constants for the stage controllers
package usc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CHECK,
        RECOVER,
        HANDOFF,
        RELEASE
    } rec_state_t;

    localparam int CHECK_CYCLES_DEF   = 2;
    localparam int RECOVER_CYCLES_DEF = 3;
    localparam int ERR_CNT_W_DEF      = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && !(&q))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/err_recovery_ctrl.sv
// err_recovery_ctrl: sample, error-check window, timed goml recovery and four-phase downstream handoff
module err_recovery_ctrl
    import usc_ctrl_pkg::*;
#(
    parameter int CHECK_CYCLES   = CHECK_CYCLES_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF,
    parameter int CNT_W          = ERR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lreq,
    output logic             lack,
    input  logic             err0,
    input  logic             err1,
    output logic             sample,
    output logic             goml,
    output logic             rreq,
    input  logic             rack,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       last_err
);

    localparam int MAX_CYC = (CHECK_CYCLES > RECOVER_CYCLES) ? CHECK_CYCLES : RECOVER_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    rec_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    last_err_q;
    logic [1:0]    last_err_d;
    logic          inc;

    assign last_err_d = last_err_q | {err1, err0};
    // one increment per recovery: only on the CHECK->RECOVER transition
    assign inc = (state_q == CHECK) && (cnt_q == '0) && (|last_err_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_err_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (lreq) state_q <= SAMPLE;
                SAMPLE: begin
                    state_q    <= CHECK;
                    cnt_q      <= CW'(CHECK_CYCLES - 1);
                    last_err_q <= '0;
                end
                CHECK: begin
                    last_err_q <= last_err_d;
                    if (cnt_q == '0) begin
                        state_q <= (|last_err_d) ? RECOVER : HANDOFF;
                        cnt_q   <= CW'(RECOVER_CYCLES - 1);
                    end else
                        cnt_q <= cnt_q - 1'b1;
                end
                RECOVER: begin
                    if (cnt_q == '0)
                        state_q <= HANDOFF;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                HANDOFF: if (rack) state_q <= RELEASE;
                RELEASE: if (!rack && !lreq) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample   = (state_q == SAMPLE);
    assign goml     = (state_q == RECOVER);
    assign rreq     = (state_q == HANDOFF);
    assign lack     = (state_q == RELEASE);
    assign last_err = last_err_q;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (inc),
        .q   (err_count)
    );

endmodule

// File: tb/tb_err_recovery_ctrl.sv
// tb_err_recovery_ctrl: randomized token driver with scoreboard monitor for err_recovery_ctrl
module tb_err_recovery_ctrl;

    localparam int C    = 2;
    localparam int R    = 3;
    localparam int W    = 2;
    localparam int MAXC = (1 << W) - 1;

    typedef struct {
        int         lt;
        int         rt;
        int         g;
        logic [1:0] le;
        int         cnt;
    } exp_t;

    logic         clk = 0;
    logic         rst;
    logic         lreq, lack, err0, err1, sample, goml, rreq, rack, clr_cnt;
    logic [W-1:0] err_count;
    logic [1:0]   last_err;

    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   m_cnt = 0;
    exp_t sq[$];
    int   rise_q[$];
    int   fall_q[$];

    err_recovery_ctrl #(.CHECK_CYCLES(C), .RECOVER_CYCLES(R), .CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .lreq      (lreq),
        .lack      (lack),
        .err0      (err0),
        .err1      (err1),
        .sample    (sample),
        .goml      (goml),
        .rreq      (rreq),
        .rack      (rack),
        .clr_cnt   (clr_cnt),
        .err_count (err_count),
        .last_err  (last_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        nchk++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares on every output event against the scoreboard
    int   s_t = 0, gcnt = 0;
    logic p_s = 0, p_r = 0, p_l = 0;
    always @(negedge clk) begin
        exp_t e;
        if (sample && !p_s) begin
            s_t  = cyc;
            gcnt = 0;
        end
        if (goml) gcnt++;
        if (rreq && !p_r) begin
            if (sq.size() == 0)
                check("sb_empty_rreq", 1, 0);
            else begin
                e = sq.pop_front();
                check("sample_time", s_t, e.lt + 1);
                check("rreq_time", cyc, e.rt);
                check("goml_cycles", gcnt, e.g);
                check("last_err", int'(last_err), int'(e.le));
                check("err_count", int'(err_count), e.cnt);
            end
            gcnt = 0;
        end
        if (lack && !p_l) begin
            if (rise_q.size() == 0)
                check("sb_empty_lack", 1, 0);
            else
                check("lack_rise_time", cyc, rise_q.pop_front());
            check("rreq_low_at_lack", int'(rreq), 0);
        end
        if (!lack && p_l) begin
            if (fall_q.size() == 0)
                check("sb_empty_lackfall", 1, 0);
            else
                check("lack_fall_time", cyc, fall_q.pop_front());
        end
        p_s = sample;
        p_r = rreq;
        p_l = lack;
    end

    task automatic tick();
        @(negedge clk);
        {err1, err0} = 2'($urandom_range(0, 3));
        clr_cnt = 0;
    endtask

    task automatic do_reset();
        #2 rst = 1;
        #1;
        check("rst_async_goml", int'(goml), 0);
        check("rst_async_rreq", int'(rreq), 0);
        check("rst_async_lack", int'(lack), 0);
        check("rst_async_count", int'(err_count), 0);
        check("rst_async_last_err", int'(last_err), 0);
        m_cnt = 0;
        lreq = 0;
        rack = 0;
        clr_cnt = 0;
        tick();
        tick();
        rst = 0;
    endtask

    // mode: 0 random, 1 forced error, 2 clean, 3 err1 in last window cycle, 4 both flags whole window
    // clr_mode: 0 none, 1 before token, 2 coinciding with increment, 3 random
    // abort: 0 none, 1 reset in RECOVER, 2 reset in HANDOFF
    task automatic run_token(input int mode, input int clr_mode, input bit early_rack, input int abort);
        exp_t       e;
        int         L, A, rt, n;
        logic [1:0] le, v;
        bit         ca, cb;
        L  = cyc;
        lreq = 1;
        le = 0;
        ca = (clr_mode == 1) || (clr_mode == 3 && $urandom_range(0, 9) == 0);
        cb = (clr_mode == 2) || (clr_mode == 3 && $urandom_range(0, 9) == 0);
        clr_cnt = ca;
        for (int k = 1; k <= 1 + C; k++) begin
            tick();
            if (k >= 2) begin
                if (mode == 2)
                    v = 2'b00;
                else if (mode == 3)
                    v = (k == 1 + C) ? 2'b10 : 2'b00;
                else if (mode == 4)
                    v = 2'b11;
                else
                    v = {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)};
                if (mode == 1 && k == 1 + C && (le | v) == 2'b00) v = 2'b01;
                {err1, err0} = v;
                le |= v;
            end
            if (k == 1 + C) clr_cnt = cb;
        end
        if (ca) m_cnt = 0;
        if (cb) m_cnt = 0;
        else if (|le) m_cnt = (m_cnt == MAXC) ? m_cnt : m_cnt + 1;
        rt = L + 2 + C + ((|le) ? R : 0);
        if (abort == 1) begin
            tick();
            tick();
            check("goml_before_abort", int'(goml), 1);
            do_reset();
            return;
        end
        e.lt = L; e.rt = rt; e.g = (|le) ? R : 0; e.le = le; e.cnt = m_cnt;
        sq.push_back(e);
        A = cyc;
        if (early_rack) rack = 1;
        n = 0;
        while (!rreq && n < 20) begin
            tick();
            n++;
        end
        check("rreq_timeout", int'(rreq), 1);
        if (abort == 2) begin
            repeat ($urandom_range(0, 2)) tick();
            do_reset();
            return;
        end
        if (!early_rack) begin
            repeat ($urandom_range(0, 3)) tick();
            rack = 1;
            A = cyc;
        end
        rise_q.push_back(((A > rt) ? A : rt) + 1);
        n = 0;
        while (!lack && n < 20) begin
            tick();
            n++;
        end
        check("lack_timeout", int'(lack), 1);
        repeat ($urandom_range(0, 3)) tick();
        rack = 0;
        repeat (early_rack ? 5 : $urandom_range(0, 5)) tick();
        lreq = 0;
        fall_q.push_back(cyc + 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; lreq = 1; rack = 0; clr_cnt = 0; err0 = 0; err1 = 0;
        repeat (3) @(negedge clk);
        check("rst_sample", int'(sample), 0);
        check("rst_goml", int'(goml), 0);
        check("rst_rreq", int'(rreq), 0);
        check("rst_lack", int'(lack), 0);
        check("rst_count", int'(err_count), 0);
        check("rst_last_err", int'(last_err), 0);
        rst = 0;
        run_token(2, 0, 0, 0);
        run_token(3, 0, 0, 0);
        run_token(4, 1, 0, 0);
        run_token(1, 1, 0, 0);
        repeat (6) run_token(1, 0, 0, 0);
        run_token(1, 2, 0, 0);
        run_token(2, 0, 1, 0);
        run_token(1, 0, 1, 0);
        run_token(1, 0, 0, 1);
        run_token(2, 0, 0, 2);
        run_token(2, 0, 0, 0);
        repeat (40) run_token($urandom_range(0, 2), 3, 1'($urandom_range(0, 3) == 0), 0);
        repeat (3) tick();
        check("sb_leftover", sq.size(), 0);
        check("rise_leftover", rise_q.size(), 0);
        check("fall_leftover", fall_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
